// File: rtl/led_fader.sv
// rtl/led_fader.sv - PWM LED fader with linear ramp up/down to a programmable brightness
//
// Purpose:
//   Takes the blinker's on/off request and turns it into a PWM drive that
//   ramps duty linearly, one LSB every RAMP_STEP_CYCLES clocks, up to
//   brightness (led_req=1) or down to zero (led_req=0).
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   led_req     requested LED state from the blinker (1 = on)
//   brightness  target duty while led_req=1
//   led_out     registered PWM drive (high while pwm_cnt < duty)
//   duty        current duty value
//   busy        high while ramping (UP or DOWN)

module led_fader #(
  parameter int PWM_BITS         = 8,
  parameter int RAMP_STEP_CYCLES = 390625
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                led_req,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                led_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam int SW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam logic [SW-1:0]       STEP_LAST = SW'(RAMP_STEP_CYCLES - 1);
  localparam logic [SW-1:0]       STEP_ONE  = SW'(1);
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_HOLD = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  state_t              r_state;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic [SW-1:0]       r_step_cnt;
  logic                r_led_out;
  logic                r_busy;

  logic [PWM_BITS-1:0] w_target;
  logic                w_step_term;
  logic [PWM_BITS-1:0] w_duty_nxt;

  // The step is taken only if it still moves toward the (possibly new) target,
  // so a target change on a terminal cycle can never cause an overshoot. Since
  // target is bounded by the PWM range, duty < target also blocks the increment
  // at full scale, and duty > target blocks the decrement at zero.
  always_comb begin
    w_target    = led_req ? brightness : '0;
    w_step_term = (r_step_cnt == STEP_LAST);
    w_duty_nxt  = r_duty;
    if (r_state == S_UP && w_step_term && r_duty < w_target) begin
      w_duty_nxt = r_duty + DUTY_ONE;
    end else if (r_state == S_DOWN && w_step_term && r_duty > w_target) begin
      w_duty_nxt = r_duty - DUTY_ONE;
    end
  end

  // State is chosen from the post-step duty against the current target, so
  // the cycle that lands on target already leaves UP/DOWN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pwm_cnt  <= '0;
      r_duty     <= '0;
      r_step_cnt <= '0;
      r_led_out  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + DUTY_ONE;
      r_led_out <= (r_pwm_cnt < r_duty);
      r_duty    <= w_duty_nxt;

      if (w_duty_nxt < w_target) begin
        r_state <= S_UP;
        r_busy  <= 1'b1;
        // Entering UP (including a reversal) restarts the step interval.
        if (r_state != S_UP || w_step_term) begin
          r_step_cnt <= '0;
        end else begin
          r_step_cnt <= r_step_cnt + STEP_ONE;
        end
      end else if (w_duty_nxt > w_target) begin
        r_state <= S_DOWN;
        r_busy  <= 1'b1;
        if (r_state != S_DOWN || w_step_term) begin
          r_step_cnt <= '0;
        end else begin
          r_step_cnt <= r_step_cnt + STEP_ONE;
        end
      end else begin
        r_state    <= (w_duty_nxt == '0) ? S_IDLE : S_HOLD;
        r_busy     <= 1'b0;
        r_step_cnt <= '0;
      end
    end
  end

  assign led_out = r_led_out;
  assign duty    = r_duty;
  assign busy    = r_busy;

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - scoreboard bench for led_fader (PWM_BITS=4, RAMP_STEP_CYCLES=3)

module tb_led_fader;

  localparam int PB   = 4;
  localparam int STEP = 3;
  localparam int PER  = 1 << PB;

  logic          clk = 1'b0;
  logic          reset;
  logic          led_req;
  logic [PB-1:0] brightness;
  logic          led_out;
  logic [PB-1:0] duty;
  logic          busy;

  led_fader #(.PWM_BITS(PB), .RAMP_STEP_CYCLES(STEP)) dut (
    .clk        (clk),
    .reset      (reset),
    .led_req    (led_req),
    .brightness (brightness),
    .led_out    (led_out),
    .duty       (duty),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   rel_cyc   = 0;
  int   prev_duty = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, and match any duty
  // change against the head of the scoreboard (value and exact cycle).
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (int'(duty) != prev_duty) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_duty_change", int'(duty), prev_duty);
      end else begin
        e = sb_q.pop_front();
        check_eq("duty_val", int'(duty), e.val);
        check_eq("duty_cyc", cyc, e.cyc);
      end
    end
    prev_duty = int'(duty);
  endtask

  // Expected duty trajectory for a ramp whose transition edge is base+1.
  task automatic push_ramp(input int from, input int to, input int base);
    int   v;
    int   k;
    exp_t e;
    v = from;
    k = 0;
    while (v != to) begin
      v += (to > from) ? 1 : -1;
      k++;
      e.cyc = base + 1 + STEP * k;
      e.val = v;
      sb_q.push_back(e);
    end
  endtask

  task automatic run_ramp(input int end_busy);
    int budget;
    budget = 200;
    while (sb_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
      check_eq("busy", int'(busy), (sb_q.size() > 0) ? 1 : end_busy);
    end
    if (sb_q.size() > 0) begin
      check_eq("ramp_timeout_pending", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic pwm_check(input int exp_duty);
    int highs;
    int phase;
    highs = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      phase = (cyc - rel_cyc - 1) % PER;
      check_eq("pwm_phase", int'(led_out), (phase < exp_duty) ? 1 : 0);
      highs += int'(led_out);
    end
    check_eq("pwm_high_cnt", highs, exp_duty);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq(tag, int'(led_out), 0);
      check_eq("idle_busy", int'(busy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    led_req    = 1'b1;
    brightness = 4'd15;

    // Held in reset with an active request: nothing may move.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rst_led_out", int'(led_out), 0);
      check_eq("rst_duty", int'(duty), 0);
      check_eq("rst_busy", int'(busy), 0);
    end

    // Release: full ramp 0->15, first step 3 cycles after entering UP.
    push_ramp(0, 15, cyc);
    reset   = 1'b1;
    rel_cyc = cyc;
    run_ramp(0);
    check_eq("full_duty", int'(duty), 15);

    // Full-scale PWM: 15 of 16 high.
    pwm_check(15);

    // Ramp down to off.
    led_req = 1'b0;
    push_ramp(15, 0, cyc);
    run_ramp(0);
    tick();
    idle_check("off_led_out", 20);

    // Ramp up to 8, hold, check PWM at half duty.
    led_req    = 1'b1;
    brightness = 4'd8;
    push_ramp(0, 8, cyc);
    run_ramp(0);
    check_eq("hold8_duty", int'(duty), 8);
    pwm_check(8);

    // Ramp down from 8 over 24 cycles.
    led_req = 1'b0;
    push_ramp(8, 0, cyc);
    run_ramp(0);
    tick();
    idle_check("down8_led_out", 16);

    // brightness=0 with led_req=1 behaves as off.
    led_req    = 1'b1;
    brightness = 4'd0;
    idle_check("zero_bright_led_out", 12);
    check_eq("zero_bright_duty", int'(duty), 0);

    // Reversal at duty 5: next step is 5->4, three cycles after the turn.
    brightness = 4'd15;
    push_ramp(0, 5, cyc);
    run_ramp(1);
    check_eq("rev_at5", int'(duty), 5);
    led_req = 1'b0;
    push_ramp(5, 0, cyc);
    run_ramp(0);
    tick();
    idle_check("rev_led_out", 8);

    // Async reset mid-ramp at duty 6.
    led_req = 1'b1;
    push_ramp(0, 6, cyc);
    run_ramp(1);
    check_eq("pre_arst_duty", int'(duty), 6);
    #3;
    reset = 1'b0;
    #1;
    check_eq("arst_duty", int'(duty), 0);
    check_eq("arst_led_out", int'(led_out), 0);
    check_eq("arst_busy", int'(busy), 0);
    prev_duty = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("arst_hold_duty", int'(duty), 0);
    end
    check_eq("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
